// File: rtl/dac_sample_feeder.sv
// dac_sample_feeder: FIFO-buffered, rate-paced sample feeder for the AD5660 serializer.
// Define DAC_FEEDER_HOLD_EN to repeat the last popped word on underrun instead of midscale.
module dac_sample_feeder #(
  parameter int IN_BITS  = 18,
  parameter int OUT_BITS = 16,
  parameter int DEPTH    = 4,
  parameter int fCLK     = 50_000_000,
  parameter int fSAMPLE  = 48_000,
  parameter int MIN_GAP  = 100
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [IN_BITS-1:0]    s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [OUT_BITS-1:0]          dac_in,
  output logic                         dac_go,
  output logic                         underrun,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int DIV = fCLK / fSAMPLE;
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = $clog2(DEPTH + 1);
  localparam int CW  = $clog2(DIV);
  localparam logic [OUT_BITS-1:0] MID = {1'b1, {(OUT_BITS-1){1'b0}}};
  localparam logic signed [IN_BITS-1:0] MAXV = IN_BITS'(2**(OUT_BITS-1) - 1);
  localparam logic signed [IN_BITS-1:0] MINV = IN_BITS'(-(2**(OUT_BITS-1)));

  if (DIV < MIN_GAP) begin : g_gap_check
    $error("dac_sample_feeder: fCLK/fSAMPLE below MIN_GAP");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t                r_state, w_next;
  logic [OUT_BITS-1:0]   r_mem [DEPTH];
  logic [AW-1:0]         r_wp, r_rp;
  logic [LW-1:0]         r_level;
  logic [CW-1:0]         r_cnt;
  logic [1:0]            r_ucnt;
  logic                  w_push, w_tick, w_pop, w_under;
  logic [OUT_BITS-1:0]   w_conv, w_fallback;

  assign s_ready = !reset && (r_level < LW'(DEPTH));
  assign level   = r_level;
  assign w_push  = s_valid && s_ready;
  // Saturate to the DAC range; flipping the MSB turns two's complement into offset binary.
  assign w_conv  = (s_data > MAXV) ? '1 : (s_data < MINV) ? '0 :
                   {~s_data[OUT_BITS-1], s_data[OUT_BITS-2:0]};

`ifdef DAC_FEEDER_HOLD_EN
  logic [OUT_BITS-1:0] r_last;
  // Remember the last real sample so an underrun repeats it.
  always_ff @(posedge clk) begin
    if (reset) r_last <= MID;
    else if (w_pop) r_last <= r_mem[r_rp];
  end
  assign w_fallback = r_last;
`else
  assign w_fallback = MID;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end

  // Start once primed to half depth; fall back to IDLE on the fourth consecutive underrun.
  always_comb begin
    w_next = (r_state == IDLE) ? ((r_level >= LW'(DEPTH/2)) ? RUN : IDLE) :
             (w_under && r_ucnt == 2'd3) ? IDLE : RUN;
  end

  // Tick decode and pop/underrun decisions.
  always_comb begin
    w_tick  = (r_state == RUN) && (r_cnt == CW'(DIV - 1));
    w_pop   = w_tick && (r_level != '0);
    w_under = w_tick && (r_level == '0);
  end

  // Sample-rate divider (parked at 0 outside RUN) and consecutive-underrun count (wraps to 0 on the 4th).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_ucnt <= '0;
    end else begin
      r_cnt  <= (r_state == RUN && w_next == RUN && !w_tick) ? r_cnt + 1'b1 : '0;
      r_ucnt <= w_pop ? 2'd0 : w_under ? r_ucnt + 1'b1 : r_ucnt;
    end
  end

  // FIFO storage holds already-converted words.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= w_conv;
  end

  // FIFO pointers and occupancy; push and pop in one cycle cancel in the level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      r_wp    <= w_push ? r_wp + 1'b1 : r_wp;
      r_rp    <= w_pop ? r_rp + 1'b1 : r_rp;
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  // Registered serializer outputs; dac_in holds between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      dac_in   <= MID;
      dac_go   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      dac_go   <= w_tick;
      underrun <= w_under;
      dac_in   <= w_pop ? r_mem[r_rp] : w_under ? w_fallback : dac_in;
    end
  end
endmodule

// File: tb/tb_dac_sample_feeder.sv
// tb_dac_sample_feeder: directed and randomized checks of dac_sample_feeder against a queue-based model.
module tb_dac_sample_feeder;
  localparam int DIV   = 50_000_000 / 48_000;
  localparam int DEPTH = 4;
`ifdef DAC_FEEDER_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1, s_valid = 1'b0;
  logic signed [17:0] s_data = '0;
  logic s_ready, dac_go, underrun;
  logic [15:0] dac_in;
  logic [2:0] level;
  int errors = 0, checks = 0;

  logic [15:0] q[$];
  bit m_run = 0, e_go = 0, e_under = 0;
  int m_start = 0, m_ucnt = 0, cyc = 0;
  logic [15:0] m_last = 16'h8000, e_din = 16'h8000;

  always #5 clk = ~clk;

  dac_sample_feeder dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .dac_in(dac_in), .dac_go(dac_go), .underrun(underrun), .level(level)
  );

  function automatic logic [15:0] conv(int v);
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return 16'(v + 32768);
  endfunction

  function automatic int rnd();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  task automatic step();
    int sz = q.size();
    bit push = s_valid && !reset && sz < DEPTH;
    bit tick = m_run && ((cyc - m_start) % DIV == DIV - 1);
    logic [15:0] w = conv(int'(s_data));
    bit n_go = 0, n_under = 0;
    if (reset) begin
      q.delete(); m_run = 0; m_ucnt = 0; m_last = 16'h8000; e_din = 16'h8000;
    end else begin
      if (tick) begin
        n_go = 1;
        if (sz > 0) begin
          e_din = q.pop_front(); m_last = e_din; m_ucnt = 0;
        end else begin
          n_under = 1; e_din = HOLD ? m_last : 16'h8000; m_ucnt++;
          if (m_ucnt == 4) begin m_run = 0; m_ucnt = 0; end
        end
      end else if (!m_run && sz >= DEPTH / 2) begin
        m_run = 1; m_start = cyc + 1;
      end
      if (push) q.push_back(w);
    end
    @(posedge clk); #1;
    cyc++; e_go = n_go; e_under = n_under;
  endtask

  task automatic push(int v);
    s_data = 18'(v); s_valid = 1'b1; step(); s_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    s_valid = 1'b0; reset = 1'b1; step(); reset = 1'b0; step();
  endtask

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b1; s_data = 18'sd5;
    repeat (3) step();
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", s_ready); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (dac_in !== 16'h8000) begin errors++; $display("FAIL reset_dac_in got %h want 8000", dac_in); end
    checks++; if (dac_go !== 1'b0 || underrun !== 1'b0) begin errors++; $display("FAIL reset_strobes got go=%b under=%b want 0 0", dac_go, underrun); end
    s_valid = 1'b0; reset = 1'b0; step();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", s_ready); end
    checks++; if (dac_go !== 1'b0) begin errors++; $display("FAIL reset_release_go got %b want 0", dac_go); end
  endtask

  task automatic test_conversion();
    int vals[6] = '{0, -1, 'h1FFFF, -131072, 40000, -40000};
    logic [15:0] want[6] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    int n = 0, pushed = 0;
    for (int i = 0; i < 12 * DIV && n < 6; i++) begin
      s_valid = (pushed < 6) && s_ready;
      if (s_valid) begin s_data = 18'(vals[pushed]); pushed++; end
      step();
      if (dac_go && n < 6) begin
        checks++; if (dac_in !== want[n] || underrun !== 1'b0) begin errors++; $display("FAIL conv_%0d got %h under=%b want %h under=0", n, dac_in, underrun, want[n]); end
        n++;
      end
    end
    s_valid = 1'b0;
    checks++; if (n != 6) begin errors++; $display("FAIL conv_strobe_count got %0d want 6", n); end
    reset_pulse();
  endtask

  task automatic test_prime_underrun();
    int gos = 0, n = 0, c, last = 0;
    logic [15:0] fb = HOLD ? 16'h5678 : 16'h8000;
    push(4660 - 32768);
    repeat (2 * DIV) begin step(); if (dac_go) gos++; end
    checks++; if (gos != 0 || level !== 3'd1) begin errors++; $display("FAIL prime_one got strobes=%0d level=%0d want 0 1", gos, level); end
    c = cyc;
    push(22136 - 32768);
    for (int i = 0; i < 8 * DIV && n < 6; i++) begin
      step();
      if (dac_go) begin
        if (n == 0) begin
          checks++; if (cyc != c + DIV + 2) begin errors++; $display("FAIL first_strobe got cycle %0d want %0d", cyc, c + DIV + 2); end
        end else begin
          checks++; if (cyc - last != DIV) begin errors++; $display("FAIL strobe_gap_%0d got %0d want %0d", n, cyc - last, DIV); end
        end
        checks++;
        if (n == 0 && (dac_in !== 16'h1234 || underrun !== 1'b0)) begin errors++; $display("FAIL prime_data0 got %h under=%b want 1234 0", dac_in, underrun); end
        else if (n == 1 && (dac_in !== 16'h5678 || underrun !== 1'b0)) begin errors++; $display("FAIL prime_data1 got %h under=%b want 5678 0", dac_in, underrun); end
        else if (n > 1 && (dac_in !== fb || underrun !== 1'b1)) begin errors++; $display("FAIL underrun_%0d got %h under=%b want %h 1", n, dac_in, underrun, fb); end
        last = cyc; n++;
      end else begin
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_without_go got 1 want 0"); end
      end
    end
    checks++; if (n != 6) begin errors++; $display("FAIL prime_strobe_count got %0d want 6", n); end
    gos = 0;
    repeat (2 * DIV) begin step(); if (dac_go) gos++; end
    checks++; if (gos != 0) begin errors++; $display("FAIL idle_after_underrun got %0d strobes want 0", gos); end
    reset_pulse();
  endtask

  task automatic test_back_pressure();
    int acc = 0;
    bit seen = 0;
    s_valid = 1'b1;
    repeat (10) begin
      if (s_ready) acc++;
      s_data = 18'(rnd());
      step();
      if (level == 3'd4) begin
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", s_ready); end
      end
    end
    checks++; if (acc != 4 || level !== 3'd4) begin errors++; $display("FAIL bp_accept got acc=%0d level=%0d want 4 4", acc, level); end
    for (int i = 0; i < 2 * DIV && !seen; i++) begin
      s_data = 18'(rnd());
      step();
      seen = dac_go;
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_pop_timeout got no strobe want strobe"); end
    checks++; if (s_ready !== 1'b1 || level !== 3'd3) begin errors++; $display("FAIL bp_after_pop got ready=%b level=%0d want 1 3", s_ready, level); end
    checks++; if (dac_in !== e_din) begin errors++; $display("FAIL bp_head got %h want %h", dac_in, e_din); end
    step();
    checks++; if (s_ready !== 1'b0 || level !== 3'd4) begin errors++; $display("FAIL bp_refill got ready=%b level=%0d want 0 4", s_ready, level); end
    reset_pulse();
  endtask

  task automatic test_reset_mid();
    int gos = 0;
    push(100); push(-100); push(3000);
    step();
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL mid_level_pre got %0d want 3", level); end
    repeat (DIV / 2) step();
    reset = 1'b1; step();
    checks++; if (level !== 3'd0 || dac_in !== 16'h8000 || dac_go !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL mid_reset got level=%0d din=%h go=%b ready=%b want 0 8000 0 0", level, dac_in, dac_go, s_ready); end
    reset = 1'b0; step();
    checks++; if (dac_go !== 1'b0 || level !== 3'd0 || s_ready !== 1'b1) begin errors++; $display("FAIL mid_release got go=%b level=%0d ready=%b want 0 0 1", dac_go, level, s_ready); end
    repeat (2 * DIV) begin step(); if (dac_go) gos++; end
    checks++; if (gos != 0) begin errors++; $display("FAIL mid_idle got %0d strobes want 0", gos); end
  endtask

  task automatic test_simultaneous();
    int a = rnd(), b = rnd(), cb;
    push(a);
    cb = cyc;
    push(b);
    while (cyc < cb + DIV + 1) step();
    push(rnd());
    checks++; if (dac_go !== 1'b1 || dac_in !== conv(a)) begin errors++; $display("FAIL simul_pop got go=%b din=%h want 1 %h", dac_go, dac_in, conv(a)); end
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL simul_level got %0d want 2", level); end
    reset_pulse();
  endtask

  task automatic test_random();
    for (int i = 0; i < 30000; i++) begin
      s_valid = (i < 10000) ? ($urandom_range(0, 699) == 0) : ($urandom_range(0, 2499) == 0);
      s_data = 18'(rnd());
      step();
      checks++;
      if ({dac_go, underrun, level, dac_in} !== {e_go, e_under, 3'(q.size()), e_din} || s_ready !== (q.size() < DEPTH)) begin
        errors++;
        $display("FAIL random_cycle_%0d got go=%b under=%b level=%0d din=%h ready=%b want %b %b %0d %h %b",
                 cyc, dac_go, underrun, level, dac_in, s_ready, e_go, e_under, q.size(), e_din, q.size() < DEPTH);
      end
    end
    s_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_conversion();
    test_prime_underrun();
    test_back_pressure();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dac_sample_feeder.md
# dac_sample_feeder

Sample pacing and format stage that sits directly upstream of the AD5660 DAC SPI serializer. It accepts signed audio samples from the synthesis datapath over a valid/ready handshake and buffers them in a small FIFO. Each sample is saturated to the DAC width and converted to offset binary, then presented to the serializer as a data word plus a one-cycle `go` strobe at a fixed sample rate. Underruns are detected, flagged and recovered from without stalling the serializer.

## Interface

Parameters:

- `IN_BITS`, 18: width of signed input sample.
- `OUT_BITS`, 16: DAC word width; must equal the serializer `BITS`.
- `DEPTH`, 4: FIFO entries, power of two, ≥ 2.
- `fCLK`, 50_000_000: clock frequency in Hz.
- `fSAMPLE`, 48_000: output sample rate in Hz.
- `MIN_GAP`, 100: minimum clocks between `dac_go` strobes.
  - Elaboration error if `fCLK/fSAMPLE < MIN_GAP`.

Ports:

- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  system clock.
  - `reset`  in  1  synchronous, active-high reset.
- Input side:
  - `s_data`  in  `IN_BITS`  signed two's-complement sample.
  - `s_valid`  in  1  sample valid.
  - `s_ready`  out  1  FIFO can accept.
- Serializer side:
  - `dac_in`  out  `OUT_BITS`  offset-binary word to serializer `in`.
  - `dac_go`  out  1  one-cycle strobe to serializer `go`.
- Status:
  - `underrun`  out  1  one-cycle pulse on tick with empty FIFO.
  - `level`  out  `$clog2(DEPTH+1)`  current FIFO occupancy.

## Operation

- Write:
  - A write occurs when `s_valid && s_ready`.
  - `s_ready = !reset && (level < DEPTH)`.
  - `s_ready` does not depend on `s_valid` or on a same-cycle pop. When full, no write is accepted even if a pop occurs in the same cycle.
- Conversion, applied on write; the FIFO stores converted words:
  - Saturate `s_data` to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1].
  - Then invert the MSB.
  - Examples for 18→16 bit: 0 → 0x8000; -1 → 0x7FFF; 0x1FFFF → 0xFFFF; -131072 → 0x0000.
- Tick counter:
  - DIV = fCLK/fSAMPLE, floor (1041 at defaults).
  - Counts 0..DIV-1 and wraps; tick is asserted when count = DIV-1.
  - Held at 0 while in IDLE.
- States:
  - IDLE: no ticks and no `dac_go`. Moves to RUN when `level ≥ DEPTH/2`, i.e. the FIFO is primed.
  - RUN, tick with `level > 0`: pop the head into `dac_in`, assert `dac_go`, clear the consecutive-underrun count.
  - RUN, tick with `level == 0`: pulse `underrun`, load the fallback word into `dac_in` (see Configuration), assert `dac_go`, increment the consecutive-underrun count.
  - When the count reaches 4, the 4th underrun strobe is still issued, then the state returns to IDLE, the count clears, and the counter resets.
- Simultaneous push and pop in one cycle: `level` is unchanged and both operations take effect.
- `dac_in` holds its value between strobes. The serializer latches it on `go`.

## Timing

- Reset values:
  - `dac_in` = 2^(OUT_BITS-1) (0x8000), `dac_go` = 0, `underrun` = 0, `level` = 0, `s_ready` = 0 while `reset` is high.
  - State IDLE, FIFO pointers and counters 0.
- Reset mid-operation discards all FIFO contents. No `dac_go` is issued on the cycle `reset` is high or on the cycle after it deasserts.
- `s_ready` returns to 1 on the first cycle after `reset` deasserts.
- Write latency:
  - A word written in cycle N is reflected in `level` at N+1.
  - It is eligible for pop on a tick at N+1 or later.
- Pop latency: for a tick in cycle T, `dac_in`, `dac_go` and `underrun` are all registered and visible in cycle T+1. `dac_go` is high for exactly one cycle.
- Strobe spacing: in RUN, consecutive `dac_go` strobes are exactly DIV cycles apart.
- First-strobe latency: the first strobe after entering RUN occurs DIV cycles after the IDLE→RUN transition.

## Configuration

- Macro: `DAC_FEEDER_HOLD_EN`.
- Defined: the underrun fallback word is the last successfully popped sample, or 0x8000 if none has been popped since reset.
- Undefined: the underrun fallback word is always midscale 0x8000.
- Everything else is identical in both builds.

## Test plan

- Conversion: push 0, -1, 0x1FFFF, -131072, 40000, -40000 → `dac_in` = 0x8000, 0x7FFF, 0xFFFF, 0x0000, 0xFFFF, 0x0000 on successive strobes.
- Priming and rate:
  - Push 1 sample → no `dac_go` ever occurs.
  - Push a 2nd → first strobe 1041 cycles after RUN is entered, then every 1041 cycles.
  - No strobe gap differs from 1041.
- Back-pressure: hold `s_valid` high with no ticks → exactly 4 words accepted, `s_ready` = 0 while `level` = 4; `s_ready` rises the cycle after a pop.
- Underrun recovery:
  - Prime with 2 samples (0x1234, 0x5678 post-conversion), then stop input.
  - Expect 2 data strobes, then 4 strobes each with an `underrun` pulse, then no further strobes and the state is IDLE.
  - Strobe value is 0x5678 with `DAC_FEEDER_HOLD_EN`, 0x8000 without.
- Reset mid-run: assert `reset` for 1 cycle while `level` = 3 → `level` = 0, `dac_in` = 0x8000, no `dac_go` for ≥ 2 cycles, IDLE until re-primed.
- Simultaneous push and pop: push on the tick cycle with `level` = 2 → `level` stays 2 and the popped value is the old head.
